// File: rtl/frog_row_pkg.sv
// frog_pkg: shared types and helpers for the Frogger playfield row.
//   move_t      - decoded move request for one cycle
//   decode_move - L/R/U/D pulses to move_t; zero or several asserted -> MV_NONE
//   onehot      - MAX_WIDTH-bit vector with only bit idx set
package frog_pkg;

   typedef enum logic [2:0] {MV_NONE, MV_L, MV_R, MV_U, MV_D} move_t;

   // Widest row the onehot helper can build; rows slice the low WIDTH bits.
   localparam int MAX_WIDTH = 64;

   function automatic move_t decode_move(input logic l, input logic r,
                                         input logic u, input logic d);
      move_t m;
      case ({l, r, u, d})
         4'b1000: m = MV_L;
         4'b0100: m = MV_R;
         4'b0010: m = MV_U;
         4'b0001: m = MV_D;
         default: m = MV_NONE;
      endcase
      return m;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] onehot(input int unsigned idx);
      return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/frog_row_if.sv
// frog_row_if: move/hit pulses shared by every row of the playfield.
//   L, R, U, D - single-cycle move pulses (already edge-detected)
//   hit        - collision pulse
//   master drives the pulses, slave (each frog_row) samples them.
interface frog_row_if;
   logic L;
   logic R;
   logic U;
   logic D;
   logic hit;

   modport master (output L, R, U, D, hit);
   modport slave  (input  L, R, U, D, hit);
endinterface

// File: rtl/frog_row_cell.sv
// frog_row_cell: next-state logic and flop for one column of a frog row.
//   src_l / src_r   - bit that moves into this column on L / R (neighbour
//                     column, wrapped copy, or 0 at a clamped edge)
//   hold_l / hold_r - this column is the clamp edge for L / R: keep own bit
//   above_bit / below_bit - same column of the row above / below
//   move, hit       - decoded move (already masked by hold-off) and collision
//   rst_val         - value on reset and on hit
//   top_edge / bottom_edge - row has no neighbour above / below
//   bit_q           - registered frog light for this column
import frog_pkg::*;

module frog_row_cell (
   input  logic  clk,
   input  logic  reset,
   input  logic  src_l,
   input  logic  src_r,
   input  logic  hold_l,
   input  logic  hold_r,
   input  logic  above_bit,
   input  logic  below_bit,
   input  move_t move,
   input  logic  hit,
   input  logic  rst_val,
   input  logic  top_edge,
   input  logic  bottom_edge,
   output logic  bit_q
);

   logic bit_d;

   always_comb begin
      bit_d = bit_q;
      if (hit) begin
         bit_d = rst_val;
      end else begin
         case (move)
            MV_L: bit_d = src_l | (hold_l & bit_q);
            MV_R: bit_d = src_r | (hold_r & bit_q);
            // Vertical: the frog leaves unless this is the edge row, and
            // arrives from the neighbour unless there is none on that side.
            MV_U: bit_d = (top_edge & bit_q) | (~bottom_edge & below_bit);
            MV_D: bit_d = (bottom_edge & bit_q) | (~top_edge & above_bit);
            default: bit_d = bit_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bit_q <= rst_val;
      else       bit_q <= bit_d;
   end

endmodule

// File: rtl/frog_row.sv
// frog_row: one playfield row holding the frog's column as a one-hot (or
// empty) vector. Rows are chained through aboveRow/belowRow and all update
// on the same edge, so a vertical handoff never duplicates or loses the frog.
//   clk, reset  - clock, asynchronous active-high reset
//   ctl         - shared L/R/U/D/hit pulses (slave modport)
//   aboveRow    - row output of the row above
//   belowRow    - row output of the row below
//   row         - frog lights, one-hot or zero
//   occupied    - frog is in this row
//   frogCol     - index of the lowest set bit, 0 when empty
//   busy        - respawn hold-off active, moves ignored
import frog_pkg::*;

module frog_row #(
   parameter int WIDTH          = 16,
   parameter int IS_START       = 0,
   parameter int START_COL      = WIDTH/2-1,
   parameter int WRAP           = 1,
   parameter int TOP_EDGE       = 0,
   parameter int BOTTOM_EDGE    = 0,
   parameter int RESPAWN_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   frog_row_if.slave                ctl,
   input  logic [WIDTH-1:0]         aboveRow,
   input  logic [WIDTH-1:0]         belowRow,
   output logic [WIDTH-1:0]         row,
   output logic                     occupied,
   output logic [$clog2(WIDTH)-1:0] frogCol,
   output logic                     busy
);

   localparam int COL_W = $clog2(WIDTH);
   localparam int CNT_W = (RESPAWN_CYCLES == 0) ? 1 : $clog2(RESPAWN_CYCLES+1);

   localparam logic [MAX_WIDTH-1:0] RST_FULL = (IS_START != 0) ? onehot(START_COL) : '0;
   localparam logic [WIDTH-1:0]     RST_ROW  = RST_FULL[WIDTH-1:0];
   localparam logic [CNT_W-1:0]     RELOAD   = CNT_W'(RESPAWN_CYCLES);

   logic [WIDTH-1:0] row_bits;
   logic [WIDTH-1:0] src_l;
   logic [WIDTH-1:0] src_r;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   move_t            move_eff;

   // ---------------- hold-off counter ----------------
   always_comb begin
      cnt_d = cnt_q;
      if (ctl.hit)            cnt_d = RELOAD;
      else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != '0);

   always_comb begin
      move_eff = MV_NONE;
      if (!busy) move_eff = decode_move(ctl.L, ctl.R, ctl.U, ctl.D);
   end

   // ---------------- column cells ----------------
   // L moves toward higher index, so column c is fed from c-1; R from c+1.
   // Edge columns take the wrapped bit, or nothing when clamping.
   for (genvar c = 0; c < WIDTH; c++) begin : g_col
      if (c == 0) begin : g_l_edge
         assign src_l[c] = (WRAP != 0) ? row_bits[WIDTH-1] : 1'b0;
      end else begin : g_l_mid
         assign src_l[c] = row_bits[c-1];
      end

      if (c == WIDTH-1) begin : g_r_edge
         assign src_r[c] = (WRAP != 0) ? row_bits[0] : 1'b0;
      end else begin : g_r_mid
         assign src_r[c] = row_bits[c+1];
      end

      frog_row_cell u_cell (
         .clk         (clk),
         .reset       (reset),
         .src_l       (src_l[c]),
         .src_r       (src_r[c]),
         .hold_l      ((WRAP == 0) && (c == WIDTH-1)),
         .hold_r      ((WRAP == 0) && (c == 0)),
         .above_bit   (aboveRow[c]),
         .below_bit   (belowRow[c]),
         .move        (move_eff),
         .hit         (ctl.hit),
         .rst_val     (RST_ROW[c]),
         .top_edge    (TOP_EDGE != 0),
         .bottom_edge (BOTTOM_EDGE != 0),
         .bit_q       (row_bits[c])
      );
   end

   assign row      = row_bits;
   assign occupied = |row_bits;

   // Priority encoder, lowest set bit wins (downward scan, last hit kept).
   always_comb begin
      frogCol = '0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (row_bits[i]) frogCol = COL_W'(i);
      end
   end

endmodule

// File: tb/tb_frog_row.sv
module tb_frog_row;

   logic clk;
   logic reset;

   frog_row_if ctl ();

   // three-row chain: top / middle / bottom(start)
   logic [15:0] t_row, m_row, b_row;
   logic        t_occ, m_occ, b_occ, t_busy, m_busy, b_busy;
   logic [3:0]  t_col, m_col, b_col;
   // standalone wrap / clamp rows, start column 15, no hold-off
   logic [15:0] w1_row, w0_row;
   logic        w1_occ, w0_occ, w1_busy, w0_busy;
   logic [3:0]  w1_col, w0_col;

   int n_cmp;
   int n_fail;

   frog_row #(.WIDTH(16), .TOP_EDGE(1), .RESPAWN_CYCLES(3)) u_top (
      .clk(clk), .reset(reset), .ctl(ctl), .aboveRow(16'h0000), .belowRow(m_row),
      .row(t_row), .occupied(t_occ), .frogCol(t_col), .busy(t_busy));

   frog_row #(.WIDTH(16), .RESPAWN_CYCLES(3)) u_mid (
      .clk(clk), .reset(reset), .ctl(ctl), .aboveRow(t_row), .belowRow(b_row),
      .row(m_row), .occupied(m_occ), .frogCol(m_col), .busy(m_busy));

   frog_row #(.WIDTH(16), .BOTTOM_EDGE(1), .IS_START(1), .START_COL(7), .RESPAWN_CYCLES(3)) u_bot (
      .clk(clk), .reset(reset), .ctl(ctl), .aboveRow(m_row), .belowRow(16'h0000),
      .row(b_row), .occupied(b_occ), .frogCol(b_col), .busy(b_busy));

   frog_row #(.WIDTH(16), .IS_START(1), .START_COL(15), .WRAP(1), .TOP_EDGE(1), .BOTTOM_EDGE(1)) u_w1 (
      .clk(clk), .reset(reset), .ctl(ctl), .aboveRow(16'h0000), .belowRow(16'h0000),
      .row(w1_row), .occupied(w1_occ), .frogCol(w1_col), .busy(w1_busy));

   frog_row #(.WIDTH(16), .IS_START(1), .START_COL(15), .WRAP(0), .TOP_EDGE(1), .BOTTOM_EDGE(1)) u_w0 (
      .clk(clk), .reset(reset), .ctl(ctl), .aboveRow(16'h0000), .belowRow(16'h0000),
      .row(w0_row), .occupied(w0_occ), .frogCol(w0_col), .busy(w0_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge: hold the pulses across one rising edge, return at
   // the next negedge with the pulses cleared.
   task automatic step(input logic l, input logic r, input logic u, input logic d, input logic h);
      ctl.L = l; ctl.R = r; ctl.U = u; ctl.D = d; ctl.hit = h;
      @(negedge clk);
      ctl.L = 1'b0; ctl.R = 1'b0; ctl.U = 1'b0; ctl.D = 1'b0; ctl.hit = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_single();
      n_cmp++;
      if ((int'(t_occ) + int'(m_occ) + int'(b_occ)) != 1) begin
         n_fail++;
         $display("FAIL single_occupied: got t/m/b=%b%b%b want exactly one", t_occ, m_occ, b_occ);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (b_row !== 16'h0080) begin n_fail++; $display("FAIL reset_b_row: got %h want 0080", b_row); end
      n_cmp++; if (b_col !== 4'd7)     begin n_fail++; $display("FAIL reset_b_col: got %0d want 7", b_col); end
      n_cmp++; if (b_occ !== 1'b1)     begin n_fail++; $display("FAIL reset_b_occ: got %b want 1", b_occ); end
      n_cmp++; if (b_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
      n_cmp++; if (m_row !== 16'h0000 || m_occ !== 1'b0 || m_col !== 4'd0)
         begin n_fail++; $display("FAIL reset_m: got row=%h occ=%b col=%0d want 0000/0/0", m_row, m_occ, m_col); end
      n_cmp++; if (w1_row !== 16'h8000 || w1_col !== 4'd15)
         begin n_fail++; $display("FAIL reset_w1: got row=%h col=%0d want 8000/15", w1_row, w1_col); end
   endtask

   task automatic test_wrap_clamp();
      do_reset();
      step(1, 0, 0, 0, 0);
      n_cmp++; if (w1_row !== 16'h0001) begin n_fail++; $display("FAIL wrap_l: got %h want 0001", w1_row); end
      n_cmp++; if (w0_row !== 16'h8000) begin n_fail++; $display("FAIL clamp_l: got %h want 8000", w0_row); end
      step(0, 1, 0, 0, 0);
      n_cmp++; if (w1_row !== 16'h8000) begin n_fail++; $display("FAIL wrap_r: got %h want 8000", w1_row); end
      n_cmp++; if (w0_row !== 16'h4000) begin n_fail++; $display("FAIL clamp_row_r: got %h want 4000", w0_row); end
      n_cmp++; if (w0_col !== 4'd14)    begin n_fail++; $display("FAIL clamp_col_r: got %0d want 14", w0_col); end
      // clamp at column 0 for R
      for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0);
      n_cmp++; if (w0_row !== 16'h0001) begin n_fail++; $display("FAIL clamp_r_edge: got %h want 0001", w0_row); end
   endtask

   task automatic test_chain();
      do_reset();
      step(0, 0, 1, 0, 0);
      check_single();
      n_cmp++; if (m_row !== 16'h0080 || b_row !== 16'h0000)
         begin n_fail++; $display("FAIL chain_u1: got m=%h b=%h want 0080/0000", m_row, b_row); end
      step(0, 0, 1, 0, 0);
      check_single();
      n_cmp++; if (t_row !== 16'h0080 || t_col !== 4'd7)
         begin n_fail++; $display("FAIL chain_u2: got t=%h col=%0d want 0080/7", t_row, t_col); end
      step(0, 0, 1, 0, 0);
      check_single();
      n_cmp++; if (t_row !== 16'h0080 || m_row !== 16'h0000)
         begin n_fail++; $display("FAIL chain_u3_top: got t=%h m=%h want 0080/0000", t_row, m_row); end
      step(0, 0, 0, 1, 0);
      check_single();
      n_cmp++; if (m_row !== 16'h0080 || t_row !== 16'h0000)
         begin n_fail++; $display("FAIL chain_d_top: got t=%h m=%h want 0000/0080", t_row, m_row); end
      do_reset();
      step(0, 0, 0, 1, 0);
      check_single();
      n_cmp++; if (b_row !== 16'h0080 || m_row !== 16'h0000)
         begin n_fail++; $display("FAIL chain_d_bottom: got b=%h m=%h want 0080/0000", b_row, m_row); end
   endtask

   task automatic test_multi_move();
      do_reset();
      step(1, 0, 1, 0, 0);
      n_cmp++; if (t_row !== 16'h0000 || m_row !== 16'h0000 || b_row !== 16'h0080 || w1_row !== 16'h8000)
         begin n_fail++; $display("FAIL multi_lu: got t=%h m=%h b=%h w1=%h want 0000/0000/0080/8000", t_row, m_row, b_row, w1_row); end
   endtask

   task automatic test_respawn();
      do_reset();
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      n_cmp++; if (m_row !== 16'h0004) begin n_fail++; $display("FAIL respawn_setup: got %h want 0004", m_row); end
      step(0, 0, 0, 0, 1);
      n_cmp++; if (m_row !== 16'h0000 || b_row !== 16'h0080)
         begin n_fail++; $display("FAIL respawn_hit: got m=%h b=%h want 0000/0080", m_row, b_row); end
      n_cmp++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL respawn_busy0: got %b want 1", b_busy); end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0);
         n_cmp++; if (b_row !== 16'h0080) begin n_fail++; $display("FAIL respawn_l_ignored%0d: got %h want 0080", i, b_row); end
         n_cmp++; if (b_busy !== (i < 2)) begin n_fail++; $display("FAIL respawn_busy%0d: got %b want %b", i+1, b_busy, (i < 2)); end
      end
      step(1, 0, 0, 0, 0);
      n_cmp++; if (b_row !== 16'h0100) begin n_fail++; $display("FAIL respawn_l_accept: got %h want 0100", b_row); end
      // hit and move together: move dropped
      step(1, 0, 0, 0, 1);
      n_cmp++; if (b_row !== 16'h0080 || b_busy !== 1'b1)
         begin n_fail++; $display("FAIL hit_with_move: got row=%h busy=%b want 0080/1", b_row, b_busy); end
   endtask

   task automatic test_no_holdoff();
      do_reset();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_cmp++; if (w1_row !== 16'h8000 || w1_busy !== 1'b0)
         begin n_fail++; $display("FAIL nohold_hit: got row=%h busy=%b want 8000/0", w1_row, w1_busy); end
      step(1, 0, 0, 0, 0);
      n_cmp++; if (w1_row !== 16'h0001) begin n_fail++; $display("FAIL nohold_move: got %h want 0001", w1_row); end
   endtask

   task automatic test_reset_busy();
      do_reset();
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      n_cmp++; if (m_row !== 16'h1000) begin n_fail++; $display("FAIL rb_setup: got %h want 1000", m_row); end
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      n_cmp++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rb_busy: got %b want 1", b_busy); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (b_busy !== 1'b0 || m_busy !== 1'b0)
         begin n_fail++; $display("FAIL rb_async_busy: got b=%b m=%b want 0/0", b_busy, m_busy); end
      n_cmp++; if (b_row !== 16'h0080 || m_row !== 16'h0000)
         begin n_fail++; $display("FAIL rb_async_row: got b=%h m=%h want 0080/0000", b_row, m_row); end
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 0, 0, 0);
      n_cmp++; if (b_row !== 16'h0100) begin n_fail++; $display("FAIL rb_after: got %h want 0100", b_row); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b0;
      ctl.L = 1'b0; ctl.R = 1'b0; ctl.U = 1'b0; ctl.D = 1'b0; ctl.hit = 1'b0;
      test_reset();
      test_wrap_clamp();
      test_chain();
      test_multi_move();
      test_respawn();
      test_no_holdoff();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
